// File: rtl/micro_reg_bank_pkg.sv
// Shared constants for the micro register bank: command codes, FSM states,
// STATUS bit positions and the strobe bit position in the command word.
package micro_reg_bank_pkg;

  localparam int STROBE_BIT = 23;

  localparam logic [7:0] CMD_SOFT_RST  = 8'h01;
  localparam logic [7:0] CMD_EN_TX     = 8'h02;
  localparam logic [7:0] CMD_EN_RX     = 8'h03;
  localparam logic [7:0] CMD_PH_SEL    = 8'h04;
  localparam logic [7:0] CMD_RUN_LOG   = 8'h05;
  localparam logic [7:0] CMD_RD_LOG    = 8'h06;
  localparam logic [7:0] CMD_STATUS    = 8'h07;
  localparam logic [7:0] CMD_SNAP      = 8'h08;
  localparam logic [7:0] CMD_BER_RD    = 8'h09;
  localparam logic [7:0] CMD_CLR_FLAGS = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam int STAT_TX    = 0;
  localparam int STAT_RX    = 1;
  localparam int STAT_PH_LO = 2;
  localparam int STAT_SNAP  = 4;
  localparam int STAT_FULL  = 5;
  localparam int STAT_BAD   = 6;
  localparam int STAT_DROP  = 7;

endpackage

// File: rtl/micro_edge_det.sv
// Rising-edge detector for the command strobe; keeps a registered copy of the
// strobe so a level held high is seen as a single edge.
module micro_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);

  logic sig_q;
  logic sig_d;

  always_comb sig_d = i_sig;

  // NOTE: flops are written with <= so every register samples the pre-edge
  // values of its sources, independent of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sig_q <= 1'b0;
    else        sig_q <= sig_d;
  end

  assign o_rise = i_sig & ~sig_q;

endmodule

// File: rtl/micro_reg_bank.sv
// Microcontroller-facing register bank: strobe-qualified commands, BER snapshot
// readback and optional log-memory access (enabled by MICRO_REG_BANK_LOGMEM_EN).
module micro_reg_bank #(
  parameter int NB_CMD  = 8,
  parameter int NB_INST = 32,
  parameter int NB_CNT  = 64,
  parameter int N_CH    = 2,
  parameter int NB_ADDR = 15,
  parameter int MEM_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NB_INST-1:0]     i_cmd_from_micro,
  output logic [NB_INST-1:0]     o_data_to_micro,
  output logic                   o_ack,
  input  logic [N_CH*NB_CNT-1:0] i_ber_samp,
  input  logic [N_CH*NB_CNT-1:0] i_ber_err,
  input  logic                   i_mem_full,
  input  logic [NB_INST-1:0]     i_data_log_from_mem,
  output logic [NB_ADDR-1:0]     o_addr_log_to_mem,
  output logic                   o_read_log,
  output logic                   o_run_log,
  output logic                   o_soft_reset,
  output logic                   o_enbTx,
  output logic                   o_enbRx,
  output logic [1:0]             o_phase_sel
);

  import micro_reg_bank_pkg::*;

  localparam int N_WORDS = NB_CNT / NB_INST;
  localparam int NB_ARG  = STROBE_BIT;
  localparam int NB_LAT  = 3;

  logic strobe_rise;

  state_e                 state_q, state_d;
  logic [NB_CMD-1:0]      cmd_q, cmd_d;
  logic [NB_ARG-1:0]      arg_q, arg_d;
  logic [NB_INST-1:0]     resp_q, resp_d;
  logic [NB_INST-1:0]     data_q, data_d;
  logic                   ack_q, ack_d;
  logic                   soft_rst_q, soft_rst_d;
  logic                   tx_q, tx_d;
  logic                   rx_q, rx_d;
  logic [1:0]             ph_q, ph_d;
  logic                   drop_q, drop_d;
  logic                   bad_q, bad_d;
  logic                   snap_valid_q, snap_valid_d;
  logic [N_CH*NB_CNT-1:0] snap_samp_q, snap_samp_d;
  logic [N_CH*NB_CNT-1:0] snap_err_q, snap_err_d;

`ifdef MICRO_REG_BANK_LOGMEM_EN
  logic                   run_log_q, run_log_d;
  logic                   read_log_q, read_log_d;
  logic [NB_ADDR-1:0]     addr_q, addr_d;
  logic [NB_LAT-1:0]      lat_cnt_q, lat_cnt_d;
`endif

  logic [NB_INST-1:0] status_word;
  logic [NB_INST-1:0] ber_word;
  logic               ber_in_range;
  logic [3:0]         ber_ch;
  logic               ber_err_sel;
  logic [2:0]         ber_idx;

  micro_edge_det u_edge_det (
    .clock  (clock),
    .reset  (reset),
    .i_sig  (i_cmd_from_micro[STROBE_BIT]),
    .o_rise (strobe_rise)
  );

  assign ber_ch      = arg_q[3:0];
  assign ber_err_sel = arg_q[4];
  assign ber_idx     = arg_q[7:5];

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    status_word                         = '0;
    status_word[STAT_TX]                = tx_q;
    status_word[STAT_RX]                = rx_q;
    status_word[STAT_PH_LO +: 2]        = ph_q;
    status_word[STAT_SNAP]              = snap_valid_q;
    status_word[STAT_FULL]              = i_mem_full;
    status_word[STAT_BAD]               = bad_q;
    status_word[STAT_DROP]              = drop_q;

    ber_in_range = (int'(ber_ch) < N_CH) && (int'(ber_idx) < N_WORDS);
    ber_word     = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int w = 0; w < N_WORDS; w++) begin
        if ((int'(ber_ch) == c) && (int'(ber_idx) == w)) begin
          ber_word = ber_err_sel ? snap_err_q[c*NB_CNT + w*NB_INST +: NB_INST]
                                 : snap_samp_q[c*NB_CNT + w*NB_INST +: NB_INST];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    resp_d       = resp_q;
    data_d       = data_q;
    ack_d        = ack_q;
    soft_rst_d   = soft_rst_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    ph_d         = ph_q;
    drop_d       = drop_q;
    bad_d        = bad_q;
    snap_valid_d = snap_valid_q;
    snap_samp_d  = snap_samp_q;
    snap_err_d   = snap_err_q;
`ifdef MICRO_REG_BANK_LOGMEM_EN
    run_log_d    = 1'b0;
    read_log_d   = 1'b0;
    addr_d       = addr_q;
    lat_cnt_d    = lat_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (strobe_rise) begin
          cmd_d   = i_cmd_from_micro[NB_INST-1 -: NB_CMD];
          arg_d   = i_cmd_from_micro[NB_ARG-1:0];
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_DONE;
        resp_d  = '0;
        case (cmd_q)
          NB_CMD'(CMD_SOFT_RST): soft_rst_d = arg_q[0];
          NB_CMD'(CMD_EN_TX):    tx_d       = arg_q[0];
          NB_CMD'(CMD_EN_RX):    rx_d       = arg_q[0];
          NB_CMD'(CMD_PH_SEL):   ph_d       = arg_q[1:0];
          NB_CMD'(CMD_STATUS):   resp_d     = status_word;
          NB_CMD'(CMD_SNAP): begin
            snap_samp_d  = i_ber_samp;
            snap_err_d   = i_ber_err;
            snap_valid_d = 1'b1;
          end
          NB_CMD'(CMD_BER_RD): begin
            // An empty snapshot reads as zero and is not an error.
            if (snap_valid_q) begin
              if (ber_in_range) resp_d = ber_word;
              else              bad_d  = 1'b1;
            end
          end
          NB_CMD'(CMD_CLR_FLAGS): begin
            drop_d = 1'b0;
            bad_d  = 1'b0;
          end
`ifdef MICRO_REG_BANK_LOGMEM_EN
          NB_CMD'(CMD_RUN_LOG): run_log_d = 1'b1;
          NB_CMD'(CMD_RD_LOG): begin
            if (i_mem_full) begin
              read_log_d = 1'b1;
              addr_d     = arg_q[NB_ADDR-1:0];
              lat_cnt_d  = '0;
              state_d    = ST_MEM_WAIT;
            end else begin
              bad_d = 1'b1;
            end
          end
`endif
          default: bad_d = 1'b1;
        endcase
      end

`ifdef MICRO_REG_BANK_LOGMEM_EN
      ST_MEM_WAIT: begin
        // Read data becomes valid MEM_LAT cycles after the strobe is sampled.
        if (lat_cnt_q == NB_LAT'(MEM_LAT)) begin
          resp_d  = i_data_log_from_mem;
          state_d = ST_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
`endif

      ST_DONE: begin
        data_d  = resp_q;
        ack_d   = ~ack_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A new edge while busy is lost; flag it after CLR_FLAGS so it is not masked.
    if (strobe_rise && (state_q != ST_IDLE)) drop_d = 1'b1;
  end

  // NOTE: the snapshot bank is reset like every other flop so a readback can
  // never expose X values, even though it is wide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      arg_q        <= '0;
      resp_q       <= '0;
      data_q       <= '0;
      ack_q        <= 1'b0;
      soft_rst_q   <= 1'b0;
      tx_q         <= 1'b0;
      rx_q         <= 1'b0;
      ph_q         <= '0;
      drop_q       <= 1'b0;
      bad_q        <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_samp_q  <= '0;
      snap_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      resp_q       <= resp_d;
      data_q       <= data_d;
      ack_q        <= ack_d;
      soft_rst_q   <= soft_rst_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      ph_q         <= ph_d;
      drop_q       <= drop_d;
      bad_q        <= bad_d;
      snap_valid_q <= snap_valid_d;
      snap_samp_q  <= snap_samp_d;
      snap_err_q   <= snap_err_d;
    end
  end

`ifdef MICRO_REG_BANK_LOGMEM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_log_q  <= 1'b0;
      read_log_q <= 1'b0;
      addr_q     <= '0;
      lat_cnt_q  <= '0;
    end else begin
      run_log_q  <= run_log_d;
      read_log_q <= read_log_d;
      addr_q     <= addr_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  assign o_run_log         = run_log_q;
  assign o_read_log        = read_log_q;
  assign o_addr_log_to_mem = addr_q;
`else
  assign o_run_log         = 1'b0;
  assign o_read_log        = 1'b0;
  assign o_addr_log_to_mem = '0;

  logic cfg_unused;
  assign cfg_unused = ^{i_data_log_from_mem, NB_LAT'(MEM_LAT)};
`endif

  logic arg_unused;
  assign arg_unused = ^arg_q;

  assign o_data_to_micro = data_q;
  assign o_ack           = ack_q;
  assign o_soft_reset    = soft_rst_q;
  assign o_enbTx         = tx_q;
  assign o_enbRx         = rx_q;
  assign o_phase_sel     = ph_q;

endmodule

// File: tb/tb_micro_reg_bank.sv
// Scoreboard bench for micro_reg_bank: directed commands push expected
// response/ack cycle; a monitor pops on every o_ack toggle and compares.
module tb_micro_reg_bank;

  localparam int TB_MEM_LAT = 3;
  localparam int NB_W       = 2 * 64;

  logic              clock;
  logic              reset;
  logic [31:0]       i_cmd;
  logic [31:0]       o_data;
  logic              o_ack;
  logic [NB_W-1:0]   i_ber_samp;
  logic [NB_W-1:0]   i_ber_err;
  logic              i_mem_full;
  logic [31:0]       mem_rdata;
  logic [14:0]       o_addr;
  logic              o_read_log;
  logic              o_run_log;
  logic              o_soft_reset;
  logic              o_enbTx;
  logic              o_enbRx;
  logic [1:0]        o_phase_sel;

  micro_reg_bank #(
    .NB_CMD  (8),
    .NB_INST (32),
    .NB_CNT  (64),
    .N_CH    (2),
    .NB_ADDR (15),
    .MEM_LAT (TB_MEM_LAT)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .i_cmd_from_micro    (i_cmd),
    .o_data_to_micro     (o_data),
    .o_ack               (o_ack),
    .i_ber_samp          (i_ber_samp),
    .i_ber_err           (i_ber_err),
    .i_mem_full          (i_mem_full),
    .i_data_log_from_mem (mem_rdata),
    .o_addr_log_to_mem   (o_addr),
    .o_read_log          (o_read_log),
    .o_run_log           (o_run_log),
    .o_soft_reset        (o_soft_reset),
    .o_enbTx             (o_enbTx),
    .o_enbRx             (o_enbRx),
    .o_phase_sel         (o_phase_sel)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rl_cnt  = 0;
  int   run_cnt = 0;
  logic last_ack = 1'b0;

  // Log memory model: data valid TB_MEM_LAT cycles after the read strobe is sampled.
  logic [TB_MEM_LAT-1:0] rd_pipe = '0;
  logic [14:0]           rd_addr = '0;
  always @(posedge clock) begin
    rd_pipe <= {rd_pipe[TB_MEM_LAT-2:0], o_read_log};
    if (o_read_log) rd_addr <= o_addr;
  end
  assign mem_rdata = rd_pipe[TB_MEM_LAT-1] ? {16'hC0DE, 1'b0, rd_addr} : 32'hBAD0BAD0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial forever @(posedge clock) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry consumed per o_ack toggle.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      last_ack = 1'b0;
    end else begin
      if (o_read_log) rl_cnt++;
      if (o_run_log)  run_cnt++;
      if (o_ack !== last_ack) begin
        last_ack = o_ack;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: o_ack toggled at cycle %0d, expected no toggle", cyc);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_data"}, 64'(o_data), 64'(mon_e.data));
          check({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d responses outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  function automatic exp_t mk(input string name, input logic [31:0] data, input int c);
    exp_t e;
    e.name = name;
    e.data = data;
    e.cyc  = c;
    return e;
  endfunction

  task automatic send_cmd(input string name, input logic [7:0] code, input logic [22:0] arg,
                          input logic [31:0] exp, input int lat, input int hold);
    @(negedge clock);
    i_cmd = {code, 1'b1, arg};
    sb.push_back(mk(name, exp, cyc + 1 + lat));
    wait_drain(name);
    repeat (hold) @(negedge clock);
    i_cmd[23] = 1'b0;
    @(negedge clock);
  endtask

  // Edge while busy: strobe low then high again two cycles after the accepted edge.
  task automatic send_with_drop(input string name, input logic [7:0] code, input logic [22:0] arg,
                                input logic [31:0] exp, input int lat);
    @(negedge clock);
    i_cmd = {code, 1'b1, arg};
    sb.push_back(mk(name, exp, cyc + 1 + lat));
    @(negedge clock);
    i_cmd[23] = 1'b0;
    @(negedge clock);
    i_cmd[23] = 1'b1;
    @(negedge clock);
    i_cmd[23] = 1'b0;
    wait_drain(name);
    repeat (4) @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},     64'(o_data),       64'h0);
    check({tag, "_ack"},      64'(o_ack),        64'h0);
    check({tag, "_enbtx"},    64'(o_enbTx),      64'h0);
    check({tag, "_enbrx"},    64'(o_enbRx),      64'h0);
    check({tag, "_soft"},     64'(o_soft_reset), 64'h0);
    check({tag, "_phase"},    64'(o_phase_sel),  64'h0);
    check({tag, "_run_log"},  64'(o_run_log),    64'h0);
    check({tag, "_read_log"}, 64'(o_read_log),   64'h0);
    check({tag, "_addr"},     64'(o_addr),       64'h0);
  endtask

  initial begin
    reset      = 1'b0;
    i_cmd      = '0;
    i_ber_samp = '0;
    i_ber_err  = '0;
    i_mem_full = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    send_cmd("status_init", 8'h07, 23'h0, 32'h0000_0000, 2, 0);
    send_cmd("ber_pre_snap", 8'h09, 23'h01, 32'h0, 2, 0);
    send_cmd("status_pre_snap", 8'h07, 23'h0, 32'h0000_0000, 2, 0);

    // Held strobe: one toggle only; monitor flags any further toggle.
    send_cmd("en_tx", 8'h02, 23'h1, 32'h0, 2, 10);
    check("enbtx_level", 64'(o_enbTx), 64'h1);

    send_cmd("en_rx", 8'h03, 23'h1, 32'h0, 2, 0);
    send_cmd("ph_sel", 8'h04, 23'h2, 32'h0, 2, 0);
    check("enbrx_level", 64'(o_enbRx), 64'h1);
    check("phase_level", 64'(o_phase_sel), 64'h2);
    send_cmd("status_ctrl", 8'h07, 23'h0, 32'h0000_000B, 2, 0);

    send_cmd("soft_rst_on", 8'h01, 23'h1, 32'h0, 2, 0);
    check("soft_rst_high", 64'(o_soft_reset), 64'h1);
    send_cmd("soft_rst_off", 8'h01, 23'h0, 32'h0, 2, 0);
    check("soft_rst_low", 64'(o_soft_reset), 64'h0);

    i_ber_samp[127:64] = 64'h0000_0001_0000_0005;
    i_ber_samp[63:0]   = 64'h0000_0000_0000_1111;
    i_ber_err[63:0]    = 64'hAAAA_BBBB_CCCC_DDDD;
    i_ber_err[127:64]  = 64'h0;
    send_cmd("snap", 8'h08, 23'h0, 32'h0, 2, 0);
    i_ber_samp = ~i_ber_samp;
    i_ber_err  = ~i_ber_err;
    send_cmd("ber_ch1_s_w0", 8'h09, 23'h01, 32'h0000_0005, 2, 0);
    send_cmd("ber_ch1_s_w1", 8'h09, 23'h21, 32'h0000_0001, 2, 0);
    send_cmd("ber_ch0_e_w0", 8'h09, 23'h10, 32'hCCCC_DDDD, 2, 0);
    send_cmd("ber_ch0_e_w1", 8'h09, 23'h30, 32'hAAAA_BBBB, 2, 0);
    repeat (5) @(negedge clock);
    check("data_hold", 64'(o_data), 64'hAAAA_BBBB);
    send_cmd("status_snap", 8'h07, 23'h0, 32'h0000_001B, 2, 0);

    send_cmd("ber_ch5", 8'h09, 23'h05, 32'h0, 2, 0);
    send_cmd("status_bad_ch", 8'h07, 23'h0, 32'h0000_005B, 2, 0);
    send_cmd("clr_1", 8'h0A, 23'h0, 32'h0, 2, 0);
    send_cmd("status_clr_1", 8'h07, 23'h0, 32'h0000_001B, 2, 0);

    send_cmd("ber_word2", 8'h09, 23'h41, 32'h0, 2, 0);
    send_cmd("status_bad_word", 8'h07, 23'h0, 32'h0000_005B, 2, 0);
    send_cmd("clr_2", 8'h0A, 23'h0, 32'h0, 2, 0);

    send_cmd("unknown_3c", 8'h3C, 23'h0, 32'h0, 2, 0);
    send_cmd("status_unknown", 8'h07, 23'h0, 32'h0000_005B, 2, 0);
    send_cmd("clr_3", 8'h0A, 23'h0, 32'h0, 2, 0);

    send_with_drop("status_drop", 8'h07, 23'h0, 32'h0000_001B, 2);
    send_cmd("status_dropflag", 8'h07, 23'h0, 32'h0000_009B, 2, 0);
    send_cmd("clr_4", 8'h0A, 23'h0, 32'h0, 2, 0);
    send_cmd("status_clr_4", 8'h07, 23'h0, 32'h0000_001B, 2, 0);

`ifdef MICRO_REG_BANK_LOGMEM_EN
    run_cnt = 0;
    send_cmd("run_log", 8'h05, 23'h0, 32'h0, 2, 0);
    check("run_log_pulses", 64'(run_cnt), 64'h1);

    rl_cnt = 0;
    send_cmd("rd_log_empty", 8'h06, 23'h7FFF, 32'h0, 2, 0);
    check("rd_log_empty_strobes", 64'(rl_cnt), 64'h0);
    send_cmd("status_rd_empty", 8'h07, 23'h0, 32'h0000_005B, 2, 0);
    send_cmd("clr_5", 8'h0A, 23'h0, 32'h0, 2, 0);

    i_mem_full = 1'b1;
    send_cmd("status_full", 8'h07, 23'h0, 32'h0000_003B, 2, 0);
    rl_cnt = 0;
    send_cmd("rd_log_7fff", 8'h06, 23'h7FFF, 32'hC0DE_7FFF, 3 + TB_MEM_LAT, 0);
    check("rd_log_strobes", 64'(rl_cnt), 64'h1);
    check("rd_log_addr", 64'(o_addr), 64'h7FFF);

    rl_cnt = 0;
    send_with_drop("rd_log_drop", 8'h06, 23'h0123, 32'hC0DE_0123, 3 + TB_MEM_LAT);
    check("rd_log_drop_strobes", 64'(rl_cnt), 64'h1);
    send_cmd("status_mem_drop", 8'h07, 23'h0, 32'h0000_00BB, 2, 0);
    send_cmd("clr_6", 8'h0A, 23'h0, 32'h0, 2, 0);
    send_cmd("status_clr_6", 8'h07, 23'h0, 32'h0000_003B, 2, 0);

    // Reset while the read is in MEM_WAIT.
    @(negedge clock);
    i_cmd = {8'h06, 1'b1, 23'h0456};
    @(negedge clock);
    i_cmd[23] = 1'b0;
    @(negedge clock);
    check("pre_reset_read_log", 64'(o_read_log), 64'h1);
    #2 reset = 1'b0;
    #1 check_all_zero("abort");
`else
    rl_cnt  = 0;
    run_cnt = 0;
    send_cmd("run_log_off", 8'h05, 23'h0, 32'h0, 2, 0);
    send_cmd("status_run_off", 8'h07, 23'h0, 32'h0000_005B, 2, 0);
    send_cmd("clr_5", 8'h0A, 23'h0, 32'h0, 2, 0);
    send_cmd("rd_log_off", 8'h06, 23'h7FFF, 32'h0, 2, 0);
    send_cmd("status_rd_off", 8'h07, 23'h0, 32'h0000_005B, 2, 0);
    send_cmd("clr_6", 8'h0A, 23'h0, 32'h0, 2, 0);
    check("run_log_tied", 64'(run_cnt), 64'h0);
    check("read_log_tied", 64'(rl_cnt), 64'h0);
    check("addr_tied", 64'(o_addr), 64'h0);
    send_cmd("status_pre_abort", 8'h07, 23'h0, 32'h0000_001B, 2, 0);

    // Reset while a command is executing.
    @(negedge clock);
    i_cmd = {8'h07, 1'b1, 23'h0};
    @(negedge clock);
    i_cmd[23] = 1'b0;
    #2 reset = 1'b0;
    #1 check_all_zero("abort");
`endif
    @(negedge clock);
    #2 reset = 1'b1;
    repeat (10) @(negedge clock);
    check("abort_no_ack", 64'(o_ack), 64'h0);
    check("abort_sb_empty", 64'(sb.size()), 64'h0);

    send_cmd("post_reset_tx", 8'h02, 23'h1, 32'h0, 2, 0);
`ifdef MICRO_REG_BANK_LOGMEM_EN
    send_cmd("post_reset_status", 8'h07, 23'h0, 32'h0000_0021, 2, 0);
`else
    send_cmd("post_reset_status", 8'h07, 23'h0, 32'h0000_0001, 2, 0);
`endif
    repeat (4) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
